map_row_mux: RTL and testbench

- 8:1 selector for one 7-bit row of a game map: one of eight constant row patterns is chosen by a 3-bit map index.
- Provides a combinational preview output and a registered, clock-captured copy.
- Five instances, one per map row, sit inside the map selector block.
- The preview drives the temporary-map display during the preparation phase. The registered copy feeds game logic.

---
 rtl/map_row_mux_if.sv | 28 ++
 rtl/map_row_mux.sv | 70 +++++++
 tb/tb_map_row_mux.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/map_row_mux_if.sv
// Bus for one map-row selector.
//   in0..in7 : constant row patterns, one per map index
//   sel      : map index (3 bits)
//   load     : capture strobe for the registered copy
//   out      : combinational preview of the selected row
//   out_q    : registered copy of the selected row
//   out_vld  : high once out_q holds a captured row (sticky until reset)
// master = pattern/control source, slave = the selector.
interface map_row_mux_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [2:0]       sel;
  logic             load;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_vld;

  modport master (
    output in0, in1, in2, in3, in4, in5, in6, in7, sel, load,
    input  out, out_q, out_vld
  );

  modport slave (
    input  in0, in1, in2, in3, in4, in5, in6, in7, sel, load,
    output out, out_q, out_vld
  );
endinterface

// File: rtl/map_row_mux.sv
// map_row_mux: 8:1 selector for one row of the game map.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (clears out_q / out_vld)
//   bus   : map_row_mux_if.slave (patterns, sel, load, out, out_q, out_vld)
// out is a pure combinational preview (temporary-map display); out_q is
// captured on load and feeds game logic. out_vld marks that out_q is real.
module map_row_mux #(
  parameter int WIDTH = 7,
  parameter int N_IN  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  map_row_mux_if.slave  bus
);

  // sel is 3 bits wide, so exactly eight patterns are addressable.
  if (N_IN != 8) begin : g_n_in_chk
    $error("map_row_mux: N_IN must be 8 (got %0d)", N_IN);
  end

  logic [N_IN-1:0][WIDTH-1:0] pats;
  logic [WIDTH-1:0]           sel_row;

  assign pats    = {bus.in7, bus.in6, bus.in5, bus.in4,
                    bus.in3, bus.in2, bus.in1, bus.in0};
  // Every 3-bit code addresses a populated entry: no default needed.
  assign sel_row = pats[bus.sel];
  assign bus.out = sel_row;

  logic [WIDTH-1:0] row_q, row_d;
  logic             vld_q, vld_d;

  always_comb begin
    row_d = row_q;
    vld_d = vld_q;
    if (bus.load) begin
      row_d = sel_row;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      vld_q <= 1'b0;
    end else begin
      row_q <= row_d;
      vld_q <= vld_d;
    end
  end

  assign bus.out_q   = row_q;
  assign bus.out_vld = vld_q;

  // Known select and patterns must give a known preview.
  always_comb begin
    if (!$isunknown({pats, bus.sel}))
      a_out_known: assert (!$isunknown(bus.out));
  end

  a_load_cap: assert property (@(posedge clk) disable iff (!rst_n)
    bus.load |=> (bus.out_vld && bus.out_q == $past(sel_row)));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !bus.load |=> ($stable(bus.out_q) && $stable(bus.out_vld)));

  a_vld_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_vld |=> bus.out_vld);

endmodule

// File: tb/tb_map_row_mux.sv
// Self-checking bench for map_row_mux: directed scenarios plus a random
// run scored against a small behavioural model (selected row captured on
// each load edge, validity set by any capture, both cleared by reset).
module tb_map_row_mux;
  localparam int W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  map_row_mux_if #(.WIDTH(W)) bus ();

  map_row_mux #(.WIDTH(W), .N_IN(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0][W-1:0] pat;
  assign bus.in0 = pat[0];
  assign bus.in1 = pat[1];
  assign bus.in2 = pat[2];
  assign bus.in3 = pat[3];
  assign bus.in4 = pat[4];
  assign bus.in5 = pat[5];
  assign bus.in6 = pat[6];
  assign bus.in7 = pat[7];

  // Reference model state
  logic [W-1:0] m_row;
  logic         m_vld;

  int n_chk  = 0;
  int n_pass = 0;

  // One rising edge; the model applies the capture rule with the inputs
  // that were stable at the edge, then outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_row = '0;
      m_vld = 1'b0;
    end else if (bus.load) begin
      m_row = pat[bus.sel];
      m_vld = 1'b1;
    end
    #1;
  endtask

  task automatic chk_reg(input string name);
    n_chk++;
    if (bus.out_q !== m_row || bus.out_vld !== m_vld)
      $display("FAIL %s: out_q=%b out_vld=%b, expected out_q=%b out_vld=%b",
               name, bus.out_q, bus.out_vld, m_row, m_vld);
    else n_pass++;
  endtask

  task automatic test_reset();
    pat = {7'b1000000, 7'b0111000, 7'b1000000, 7'b0000111,
           7'b0000111, 7'b1110111, 7'b1110000, 7'b0000100};
    rst_n = 1'b0; bus.load = 1'b1; bus.sel = 3'd3;
    m_row = '0; m_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (bus.out_q !== 7'b0 || bus.out_vld !== 1'b0 || bus.out !== 7'b0000111)
        $display("FAIL reset[%0d]: out_q=%b out_vld=%b out=%b, expected 0000000 0 0000111",
                 i, bus.out_q, bus.out_vld, bus.out);
      else n_pass++;
    end
    bus.load = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk_reg("reset_release");
  endtask

  task automatic test_sweep();
    logic [W-1:0] exp_tab [8];
    exp_tab = '{7'b0000100, 7'b1110000, 7'b1110111, 7'b0000111,
                7'b0000111, 7'b1000000, 7'b0111000, 7'b1000000};
    bus.load = 1'b0;
    for (int s = 0; s < 8; s++) begin
      bus.sel = 3'(s);
      #1;
      n_chk++;
      if (bus.out !== exp_tab[s] || bus.out_q !== 7'b0)
        $display("FAIL sweep[%0d]: out=%b out_q=%b, expected out=%b out_q=0000000",
                 s, bus.out, bus.out_q, exp_tab[s]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_capture();
    bus.sel = 3'd1; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_chk++;
    if (bus.out_q !== 7'b1110000 || bus.out_vld !== 1'b1)
      $display("FAIL capture: out_q=%b out_vld=%b, expected 1110000 1", bus.out_q, bus.out_vld);
    else n_pass++;
    bus.sel = 3'd2;
    tick();
    n_chk++;
    if (bus.out !== 7'b1110111 || bus.out_q !== 7'b1110000)
      $display("FAIL capture_hold: out=%b out_q=%b, expected 1110111 1110000", bus.out, bus.out_q);
    else n_pass++;
    chk_reg("capture_model");
  endtask

  task automatic test_recapture();
    bus.sel = 3'd4; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_chk++;
    if (bus.out_q !== 7'b0000111)
      $display("FAIL recapture4: out_q=%b, expected 0000111", bus.out_q);
    else n_pass++;
    tick();
    bus.sel = 3'd7; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_chk++;
    if (bus.out_q !== 7'b1000000 || bus.out_vld !== 1'b1)
      $display("FAIL recapture7: out_q=%b out_vld=%b, expected 1000000 1", bus.out_q, bus.out_vld);
    else n_pass++;
  endtask

  task automatic test_hold();
    bus.load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.sel = (i < 3) ? 3'd1 : 3'd3;
      tick();
      n_chk++;
      if (bus.out_q !== 7'b1000000 || bus.out_vld !== 1'b1)
        $display("FAIL hold[%0d]: out_q=%b out_vld=%b, expected 1000000 1",
                 i, bus.out_q, bus.out_vld);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;   // between edges
    #1;
    m_row = '0; m_vld = 1'b0;
    n_chk++;
    if (bus.out_q !== 7'b0 || bus.out_vld !== 1'b0)
      $display("FAIL async_reset: out_q=%b out_vld=%b, expected 0000000 0",
               bus.out_q, bus.out_vld);
    else n_pass++;
    tick();
    #1 rst_n = 1'b1;
    bus.sel = 3'd0; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    n_chk++;
    if (bus.out_q !== 7'b0000100 || bus.out_vld !== 1'b1)
      $display("FAIL post_reset_load: out_q=%b out_vld=%b, expected 0000100 1",
               bus.out_q, bus.out_vld);
    else n_pass++;
  endtask

  // Back-to-back and sparse loads with random selects and occasionally
  // rewritten patterns.
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0)
        for (int k = 0; k < 8; k++) pat[k] = W'($urandom);
      bus.sel  = 3'($urandom_range(0, 7));
      bus.load = ($urandom_range(0, 2) == 0);
      #1;
      n_chk++;
      if (bus.out !== pat[bus.sel])
        $display("FAIL rand_out[%0d]: out=%b, expected %b", i, bus.out, pat[bus.sel]);
      else n_pass++;
      tick();
      chk_reg("rand_reg");
    end
    bus.load = 1'b0;
  endtask

  initial begin
    bus.sel = '0; bus.load = 1'b0;
    test_reset();
    test_sweep();
    test_capture();
    test_recapture();
    test_hold();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
